// File: rtl/uart_bus_bridge.sv
// UART-to-bus debug initiator: decodes 'W'/'R' byte commands, performs one single-word
// bus access as a second master, and returns the response bytes through the UART sender.
module uart_bus_bridge #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_status,
   input  logic [7:0]  rx_data,
   input  logic        tx_status,
   output logic        tx_en,
   output logic [7:0]  tx_data,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] Address,
   output logic [31:0] Write_data,
   input  logic [31:0] Read_data,
   output logic        busy
);

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK  = 8'h4B;
   localparam logic [7:0] RSP_BAD  = 8'h3F;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ADDR      = 3'd1,
      S_DATA      = 3'd2,
      S_REQ       = 3'd3,
      S_ACCESS    = 3'd4,
      S_SEND_WAIT = 3'd5,
      S_SEND_HOLD = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic        rx_q, rx_d;
   logic        is_wr_q, is_wr_d;
   logic [1:0]  fld_cnt_q, fld_cnt_d;
   logic [2:0]  snd_cnt_q, snd_cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] resp_q, resp_d;
   logic [31:0] tmo_q, tmo_d;
   logic        tx_en_q, tx_en_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        bus_req_q, bus_req_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] address_q, address_d;
   logic [31:0] write_data_q, write_data_d;
   logic        busy_q, busy_d;

   logic        byte_acc;
   logic        tmo_hit;
   logic [31:0] tmo_inc;

   assign byte_acc = rx_status & ~rx_q;
   assign tmo_hit  = (tmo_q >= (TIMEOUT_CYCLES - 32'd1));
   assign tmo_inc  = (tmo_q == 32'hFFFF_FFFF) ? tmo_q : (tmo_q + 32'd1);

   // Next-state and next-output computation for the command/access/response sequencer
   always_comb begin
      state_d      = state_q;
      rx_d         = rx_status;
      is_wr_d      = is_wr_q;
      fld_cnt_d    = fld_cnt_q;
      snd_cnt_d    = snd_cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_d       = resp_q;
      tmo_d        = 32'd0;
      tx_en_d      = tx_en_q;
      tx_data_d    = tx_data_q;
      bus_req_d    = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      address_d    = 32'd0;
      write_data_d = 32'd0;

      case (state_q)
         S_IDLE: begin
            if (byte_acc) begin
               if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                  is_wr_d   = (rx_data == OP_WRITE);
                  fld_cnt_d = 2'd0;
                  state_d   = S_ADDR;
               end else begin
                  resp_d    = {RSP_BAD, 24'd0};
                  snd_cnt_d = 3'd1;
                  state_d   = S_SEND_WAIT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_ADDR: begin
            if (byte_acc) begin
               addr_d    = {addr_q[23:0], rx_data};
               fld_cnt_d = fld_cnt_q + 2'd1;
               if (fld_cnt_q != 2'd3) begin
                  state_d = S_ADDR;
               end else if (is_wr_q) begin
                  state_d = S_DATA;
               end else begin
                  state_d   = S_REQ;
                  bus_req_d = 1'b1;
               end
            end else if (tmo_hit) begin
               state_d   = S_IDLE;
               addr_d    = 32'd0;
               wdata_d   = 32'd0;
               fld_cnt_d = 2'd0;
               is_wr_d   = 1'b0;
            end else begin
               tmo_d = tmo_inc;
            end
         end

         S_DATA: begin
            if (byte_acc) begin
               wdata_d   = {wdata_q[23:0], rx_data};
               fld_cnt_d = fld_cnt_q + 2'd1;
               if (fld_cnt_q == 2'd3) begin
                  state_d   = S_REQ;
                  bus_req_d = 1'b1;
               end else begin
                  state_d = S_DATA;
               end
            end else if (tmo_hit) begin
               state_d   = S_IDLE;
               addr_d    = 32'd0;
               wdata_d   = 32'd0;
               fld_cnt_d = 2'd0;
               is_wr_d   = 1'b0;
            end else begin
               tmo_d = tmo_inc;
            end
         end

         // Strobes are registered here so they appear exactly during the ACCESS cycle
         S_REQ: begin
            bus_req_d = 1'b1;
            if (bus_gnt) begin
               state_d      = S_ACCESS;
               address_d    = addr_q;
               mem_write_d  = is_wr_q;
               mem_read_d   = ~is_wr_q;
               write_data_d = is_wr_q ? wdata_q : 32'd0;
            end else begin
               state_d = S_REQ;
            end
         end

         S_ACCESS: begin
            state_d = S_SEND_WAIT;
            addr_d  = 32'd0;
            wdata_d = 32'd0;
            if (is_wr_q) begin
               resp_d    = {RSP_ACK, 24'd0};
               snd_cnt_d = 3'd1;
            end else begin
               resp_d    = Read_data;
               snd_cnt_d = 3'd4;
            end
         end

         S_SEND_WAIT: begin
            if (tx_status) begin
               tx_en_d   = 1'b1;
               tx_data_d = resp_q[31:24];
               state_d   = S_SEND_HOLD;
            end else begin
               state_d = S_SEND_WAIT;
            end
         end

         // The sender acknowledges a byte by going busy; only then move to the next one
         S_SEND_HOLD: begin
            if (!tx_status) begin
               tx_en_d   = 1'b0;
               snd_cnt_d = snd_cnt_q - 3'd1;
               resp_d    = {resp_q[23:0], 8'd0};
               state_d   = (snd_cnt_q == 3'd1) ? S_IDLE : S_SEND_WAIT;
            end else begin
               state_d = S_SEND_HOLD;
            end
         end

         default: begin
            state_d = S_IDLE;
            tx_en_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         rx_q         <= 1'b0;
         is_wr_q      <= 1'b0;
         fld_cnt_q    <= 2'd0;
         snd_cnt_q    <= 3'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         resp_q       <= 32'd0;
         tmo_q        <= 32'd0;
         tx_en_q      <= 1'b0;
         tx_data_q    <= 8'd0;
         bus_req_q    <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         address_q    <= 32'd0;
         write_data_q <= 32'd0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rx_q         <= rx_d;
         is_wr_q      <= is_wr_d;
         fld_cnt_q    <= fld_cnt_d;
         snd_cnt_q    <= snd_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_q       <= resp_d;
         tmo_q        <= tmo_d;
         tx_en_q      <= tx_en_d;
         tx_data_q    <= tx_data_d;
         bus_req_q    <= bus_req_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
         busy_q       <= busy_d;
      end
   end

   assign tx_en      = tx_en_q;
   assign tx_data    = tx_data_q;
   assign bus_req    = bus_req_q;
   assign MemRead    = mem_read_q;
   assign MemWrite   = mem_write_q;
   assign Address    = address_q;
   assign Write_data = write_data_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: stimulus pushes expected bus accesses and tx
// bytes into queues; a bus monitor and a UART sender model pop and compare them.
module tb_uart_bus_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx_status = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        tx_status = 1'b1;
   logic        tx_en;
   logic [7:0]  tx_data;
   logic        bus_req;
   logic        bus_gnt = 1'b1;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic [31:0] Read_data = 32'd0;
   logic        busy;

   int tests = 0;
   int failed = 0;
   int idle_viol = 0;
   int ack_delay = 2;

   logic [64:0] exp_bus [$];
   logic [7:0]  exp_tx [$];

   uart_bus_bridge #(.TIMEOUT_CYCLES(32'd100)) dut (
      .clk(clk), .reset(reset), .rx_status(rx_status), .rx_data(rx_data),
      .tx_status(tx_status), .tx_en(tx_en), .tx_data(tx_data),
      .bus_req(bus_req), .bus_gnt(bus_gnt), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .Write_data(Write_data), .Read_data(Read_data), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Presents one byte for one cycle; returns at the negedge of the cycle after acceptance
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data   = b;
      rx_status = 1'b1;
      @(negedge clk);
      rx_status = 1'b0;
   endtask

   task automatic send_cmd(input logic [71:0] v, input int n);
      for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(w[8*i +: 8]);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((busy || exp_tx.size() != 0 || exp_bus.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'd0, (!busy && exp_tx.size() == 0 && exp_bus.size() == 0)}, 32'd1);
   endtask

   // Bus monitor: every strobe must match the next expected access
   initial begin : bus_mon
      logic        prev;
      logic [64:0] e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (MemRead || MemWrite) begin
            if (prev) idle_viol++;
            if (MemRead && MemWrite) idle_viol++;
            if (exp_bus.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL bus_unexpected: got addr %h expected no access", Address);
            end else begin
               e = exp_bus.pop_front();
               chk("bus_we", {31'd0, MemWrite}, {31'd0, e[64]});
               chk("bus_addr", Address, e[63:32]);
               chk("bus_wdata", Write_data, e[31:0]);
            end
            prev = 1'b1;
         end else begin
            prev = 1'b0;
            if (Address != 32'd0 || Write_data != 32'd0) idle_viol++;
         end
      end
   end

   // UART sender model: takes a byte, stays ready for ack_delay cycles, then goes busy
   initial begin : sender
      logic [7:0] b;
      logic       ok;
      forever begin
         @(negedge clk);
         if (reset && tx_en && tx_status) begin
            b = tx_data;
            if (exp_tx.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL tx_unexpected: got %h expected none", b);
            end else begin
               chk("tx_byte", {24'd0, b}, {24'd0, exp_tx.pop_front()});
            end
            ok = 1'b1;
            for (int k = 0; k < ack_delay; k++) begin
               @(negedge clk);
               if (!reset) break;
               if (tx_en !== 1'b1 || tx_data !== b) ok = 1'b0;
            end
            if (ack_delay > 0) chk("tx_hold_stable", {31'd0, ok}, 32'd1);
            tx_status = 1'b0;
            @(negedge clk);
            if (reset) chk("tx_en_drop", {31'd0, tx_en}, 32'd0);
            @(negedge clk);
            tx_status = 1'b1;
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {27'd0, tx_en, bus_req, MemRead, MemWrite, busy}, 32'd0);
      chk("rst_txd", {24'd0, tx_data}, 32'd0);
      chk("rst_addr", Address, 32'd0);
      chk("rst_wdata", Write_data, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Write with immediate grant: bus_req in N+1, strobe in N+2, released in N+3
      exp_bus.push_back({1'b1, 32'h4000_000C, 32'h0000_00A5});
      exp_tx.push_back(8'h4B);
      send_cmd(72'h57_4000000C_000000A5, 9);
      chk("wr_req_n1", {30'd0, bus_req, MemWrite}, 32'd2);
      @(negedge clk);
      chk("wr_strobe", {29'd0, bus_req, MemWrite, MemRead}, 32'd6);
      @(negedge clk);
      chk("wr_release", {30'd0, bus_req, MemWrite}, 32'd0);
      wait_done("wr_done");

      // Read
      Read_data = 32'h0000_005A;
      exp_bus.push_back({1'b0, 32'h4000_0010, 32'd0});
      push_word(32'h0000_005A);
      send_cmd(72'h52_40000010, 5);
      wait_done("rd_done");

      // Grant delay
      bus_gnt   = 1'b0;
      Read_data = 32'h00A1_B2C3;
      exp_bus.push_back({1'b0, 32'h4000_0004, 32'd0});
      push_word(32'h00A1_B2C3);
      send_cmd(72'h52_40000004, 5);
      begin
         logic ok;
         ok = 1'b1;
         for (int i = 0; i < 20; i++) begin
            if (bus_req !== 1'b1 || MemRead !== 1'b0) ok = 1'b0;
            @(negedge clk);
         end
         chk("gnt_wait_req", {31'd0, ok}, 32'd1);
      end
      bus_gnt = 1'b1;
      @(negedge clk);
      chk("gnt_strobe", {30'd0, bus_req, MemRead}, 32'd3);
      wait_done("gnt_done");

      // Bad opcode
      exp_tx.push_back(8'h3F);
      send_byte(8'h11);
      chk("bad_busy", {31'd0, busy}, 32'd1);
      wait_done("bad_done");

      // Timeout: partial write abandoned exactly 100 cycles after last byte
      send_cmd(72'h57_40, 2);
      repeat (99) @(negedge clk);
      chk("tmo_before", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("tmo_after", {31'd0, busy}, 32'd0);
      repeat (50) @(negedge clk);
      Read_data = 32'h0000_005A;
      exp_bus.push_back({1'b0, 32'h4000_0010, 32'd0});
      push_word(32'h0000_005A);
      send_cmd(72'h52_40000010, 5);
      wait_done("tmo_rd_done");

      // Backpressure: sender slow to acknowledge each byte
      ack_delay = 50;
      Read_data = 32'h1234_5678;
      exp_bus.push_back({1'b0, 32'h4000_0008, 32'd0});
      push_word(32'h1234_5678);
      send_cmd(72'h52_40000008, 5);
      wait_done("bp_done");

      // Reset in the middle of a response
      Read_data = 32'hCAFE_BABE;
      exp_bus.push_back({1'b0, 32'h4000_0014, 32'd0});
      push_word(32'hCAFE_BABE);
      send_cmd(72'h52_40000014, 5);
      begin
         int n;
         n = 0;
         while (!tx_en && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk("mid_tx_seen", {31'd0, tx_en}, 32'd1);
      end
      repeat (5) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_ctrl", {27'd0, tx_en, bus_req, MemRead, MemWrite, busy}, 32'd0);
      chk("mid_rst_txd", {24'd0, tx_data}, 32'd0);
      chk("mid_rst_bus", Address | Write_data, 32'd0);
      @(negedge clk);
      exp_tx.delete();
      repeat (3) @(negedge clk);
      reset     = 1'b1;
      ack_delay = 2;
      repeat (5) @(negedge clk);

      // Recovery write after reset
      exp_bus.push_back({1'b1, 32'h4000_0020, 32'hDEAD_BEEF});
      exp_tx.push_back(8'h4B);
      send_cmd(72'h57_40000020_DEADBEEF, 9);
      wait_done("rec_done");

      repeat (5) @(negedge clk);
      chk("idle_bus_clean", idle_viol, 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
